// File: rtl/mem_access_stage_if.sv
// rtl/mem_access_stage_if.sv - data-memory req/ack bus between the MEM stage and data memory
interface mem_access_stage_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM-stage load/store unit; MEM_TIMEOUT_EN adds a REQ timeout abort
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [31:0]         alu_result_in,
    input  logic [31:0]         write_data_in,
    input  logic [4:0]          rd_in,
    input  logic                reg_write_in,
    input  logic                mem_to_reg_in,
    input  logic                mem_read_in,
    input  logic                mem_write_in,
    input  logic [1:0]          size_in,
    input  logic                unsigned_in,
    mem_access_stage_if.master  bus,
    output logic [31:0]         mem_read_data_out,
    output logic [31:0]         alu_result_out,
    output logic [4:0]          rd_out,
    output logic                mem_to_reg_out,
    output logic                reg_write_out,
    output logic                stall_out,
    output logic                misalign_out,
    output logic                bus_err_out
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t      state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        access;
    logic [1:0]  off;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc;
    logic [31:0] load_fmt;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign off = alu_result_in[1:0];

    // size 2'b11 is reserved and behaves as a word, hence size_in[1] alone selects word rules
    assign misalign_out = (mem_read_in | mem_write_in) &
                          (((size_in == 2'b01) & off[0]) | (size_in[1] & (off != 2'b00)));
    assign access         = (mem_read_in | mem_write_in) & ~misalign_out;
    assign stall_out      = access & (state_q != DONE);
    assign reg_write_out  = reg_write_in & ~misalign_out;
    assign alu_result_out = alu_result_in;
    assign rd_out         = rd_in;
    assign mem_to_reg_out = mem_to_reg_in;

    assign lane_b = bus.bus_rdata[{off, 3'b000} +: 8];
    assign lane_h = bus.bus_rdata[{off[1], 4'b0000} +: 16];

    always_comb begin
        be_calc    = 4'b1111;
        wdata_calc = write_data_in;
        load_fmt   = bus.bus_rdata;
        case (size_in)
            2'b00: begin
                be_calc    = 4'b0001 << off;
                wdata_calc = {4{write_data_in[7:0]}};
                load_fmt   = {{24{lane_b[7] & ~unsigned_in}}, lane_b};
            end
            2'b01: begin
                be_calc    = 4'b0011 << off;
                wdata_calc = {2{write_data_in[15:0]}};
                load_fmt   = {{16{lane_h[15] & ~unsigned_in}}, lane_h};
            end
            default: ;
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        err_d   = err_q;
`ifdef MEM_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (access) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    we_d    = mem_write_in;
                    addr_d  = {alu_result_in[31:2], 2'b00};
                    be_d    = be_calc;
                    wdata_d = wdata_calc;
                    err_d   = 1'b0;
`ifdef MEM_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            REQ: begin
                if (bus.bus_ack) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    if (mem_read_in & ~mem_write_in) rdata_d = load_fmt;
                end
`ifdef MEM_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign bus.bus_req      = req_q;
    assign bus.bus_we       = we_q;
    assign bus.bus_addr     = addr_q;
    assign bus.bus_wdata    = wdata_q;
    assign bus.bus_be       = be_q;
    assign mem_read_data_out = rdata_q;
`ifdef MEM_TIMEOUT_EN
    assign bus_err_out = err_q;
`else
    assign bus_err_out = 1'b0;
    logic unused_err;
    assign unused_err = err_q;
`endif
endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - randomized self-checking bench for mem_access_stage
module tb_mem_access_stage;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] alu_result_in = '0, write_data_in = '0;
    logic [4:0]  rd_in = '0;
    logic        reg_write_in = 1'b0, mem_to_reg_in = 1'b0;
    logic        mem_read_in = 1'b0, mem_write_in = 1'b0;
    logic [1:0]  size_in = '0;
    logic        unsigned_in = 1'b0;
    logic [31:0] mem_read_data_out, alu_result_out;
    logic [4:0]  rd_out;
    logic        mem_to_reg_out, reg_write_out, stall_out, misalign_out, bus_err_out;

    int checks = 0;
    int failures = 0;
    logic [31:0] model_rdata = '0;

    mem_access_stage_if bus_if ();

    mem_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .alu_result_in(alu_result_in), .write_data_in(write_data_in), .rd_in(rd_in),
        .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .size_in(size_in), .unsigned_in(unsigned_in),
        .bus(bus_if.master),
        .mem_read_data_out(mem_read_data_out), .alu_result_out(alu_result_out),
        .rd_out(rd_out), .mem_to_reg_out(mem_to_reg_out), .reg_write_out(reg_write_out),
        .stall_out(stall_out), .misalign_out(misalign_out), .bus_err_out(bus_err_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic exp_mis(input logic [1:0] sz, input int off);
        if (sz == 2'd1) return (off % 2) != 0;
        if (sz >= 2'd2) return off != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] exp_be(input logic [1:0] sz, input int off);
        if (sz == 2'd0) return 32'(1 << off);
        if (sz == 2'd1) return 32'(3 << off);
        return 32'd15;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [1:0] sz, input logic [31:0] wd);
        if (sz == 2'd0) return (wd & 32'hFF) * 32'h01010101;
        if (sz == 2'd1) return (wd & 32'hFFFF) * 32'h00010001;
        return wd;
    endfunction

    function automatic logic [31:0] exp_load(input logic [1:0] sz, input int off,
                                             input logic uns, input logic [31:0] rv);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = (rv >> (8 * off)) & 32'hFF;
            if (!uns && v >= 32'd128) v = v + 32'hFFFFFF00;
        end else if (sz == 2'd1) begin
            v = (rv >> (8 * off)) & 32'hFFFF;
            if (!uns && v >= 32'd32768) v = v + 32'hFFFF0000;
        end else begin
            v = rv;
        end
        return v;
    endfunction

    task automatic set_nop();
        mem_read_in = 1'b0; mem_write_in = 1'b0; reg_write_in = 1'b0; bus_if.bus_ack = 1'b0;
    endtask

    // delay = REQ cycle (1-based) in which ack is raised; 0 means never ack
    task automatic run_op(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [1:0] sz, input logic uns,
                          input int delay, input logic [31:0] rv);
        int off, cycles, exp_cycles;
        logic mis, rw;
        off = int'(addr % 4);
        mis = (rd | wr) & exp_mis(sz, off);
        rw  = 1'($urandom_range(0, 1));
        alu_result_in = addr; write_data_in = wd; size_in = sz; unsigned_in = uns;
        mem_read_in = rd; mem_write_in = wr; reg_write_in = rw;
        rd_in = 5'($urandom); mem_to_reg_in = 1'($urandom);
        bus_if.bus_rdata = rv; bus_if.bus_ack = 1'b0;
        #1;
        check("alu_pass", alu_result_out, addr);
        check("rd_pass", 32'(rd_out), 32'(rd_in));
        check("m2r_pass", 32'(mem_to_reg_out), 32'(mem_to_reg_in));
        check("misalign", 32'(misalign_out), 32'(mis));
        check("reg_write_out", 32'(reg_write_out), 32'(rw & ~mis));
        if (!(rd | wr) || mis) begin
            check("no_stall", 32'(stall_out), 32'd0);
            @(posedge clk); @(negedge clk);
            check("no_req", 32'(bus_if.bus_req), 32'd0);
            check("no_stall2", 32'(stall_out), 32'd0);
            check("rdata_hold", mem_read_data_out, model_rdata);
            set_nop();
            return;
        end
        cycles = 0;
        while (stall_out && cycles < 60) begin
            cycles++;
            if (cycles == 1) begin
                check("idle_req", 32'(bus_if.bus_req), 32'd0);
            end else begin
                check("req", 32'(bus_if.bus_req), 32'd1);
                check("we", 32'(bus_if.bus_we), 32'(wr));
                check("addr", bus_if.bus_addr, addr - 32'(off));
                check("be", 32'(bus_if.bus_be), exp_be(sz, off));
                check("wdata", bus_if.bus_wdata, exp_wdata(sz, wd));
            end
            bus_if.bus_ack = (delay != 0) && (cycles == delay + 1);
            @(posedge clk); @(negedge clk);
        end
        bus_if.bus_ack = 1'b0;
`ifdef MEM_TIMEOUT_EN
        exp_cycles = (delay == 0 || delay > TO) ? TO + 1 : delay + 1;
        if (exp_cycles == TO + 1 && delay != TO) model_rdata = '0;
        else if (rd & ~wr) model_rdata = exp_load(sz, off, uns, rv);
        check("bus_err", 32'(bus_err_out), 32'(exp_cycles == TO + 1 && delay != TO));
`else
        exp_cycles = delay + 1;
        if (rd & ~wr) model_rdata = exp_load(sz, off, uns, rv);
        check("bus_err", 32'(bus_err_out), 32'd0);
`endif
        check("stall_cycles", 32'(cycles), 32'(exp_cycles));
        check("done_req", 32'(bus_if.bus_req), 32'd0);
        check("load_data", mem_read_data_out, model_rdata);
        set_nop();
        @(posedge clk); @(negedge clk);
    endtask

    initial begin
        bus_if.bus_ack = 1'b0; bus_if.bus_rdata = '0;
        repeat (2) @(negedge clk);
        check("rst_req", 32'(bus_if.bus_req), 32'd0);
        check("rst_addr", bus_if.bus_addr, 32'd0);
        check("rst_be", 32'(bus_if.bus_be), 32'd0);
        check("rst_rdata", mem_read_data_out, 32'd0);
        check("rst_err", 32'(bus_err_out), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        run_op(1, 0, 32'h100, 32'h0, 2'd2, 0, 1, 32'hDEADBEEF);
        check("lw_plan", mem_read_data_out, 32'hDEADBEEF);
        run_op(1, 0, 32'h103, 32'h0, 2'd0, 0, 1, 32'h80112233);
        check("lb_plan", mem_read_data_out, 32'hFFFFFF80);
        run_op(1, 0, 32'h103, 32'h0, 2'd0, 1, 1, 32'h80112233);
        check("lbu_plan", mem_read_data_out, 32'h00000080);
        run_op(0, 1, 32'h102, 32'h0000ABCD, 2'd1, 0, 1, 32'h0);
        run_op(1, 0, 32'h101, 32'h0, 2'd2, 0, 1, 32'h0);
        run_op(1, 0, 32'h200, 32'h0, 2'd2, 0, 5, 32'h12345678);
        run_op(1, 1, 32'h204, 32'h55AA55AA, 2'd3, 0, 2, 32'hCAFEF00D);

        // ack outside REQ must be ignored
        alu_result_in = 32'h0; bus_if.bus_rdata = 32'h0BADF00D; bus_if.bus_ack = 1'b1;
        @(posedge clk); @(negedge clk);
        bus_if.bus_ack = 1'b0;
        check("stray_ack", mem_read_data_out, model_rdata);
        check("stray_req", 32'(bus_if.bus_req), 32'd0);

        for (int i = 0; i < 40; i++) begin
            logic [1:0] op;
            op = 2'($urandom_range(0, 3));
            run_op(op[0], op[1], $urandom, $urandom, 2'($urandom), 1'($urandom),
                   int'($urandom_range(1, 4)), $urandom);
        end

`ifdef MEM_TIMEOUT_EN
        run_op(1, 0, 32'h300, 32'h0, 2'd2, 0, 0, 32'hFFFFFFFF);
        check("to_err", 32'(bus_err_out), 32'd1);
        run_op(0, 1, 32'h304, 32'h11, 2'd2, 0, 1, 32'h0);
        check("to_err_clr", 32'(bus_err_out), 32'd0);
`endif

        // reset during REQ drops bus_req at once; a late ack afterwards is ignored
        alu_result_in = 32'h400; size_in = 2'd2; mem_read_in = 1'b1; mem_write_in = 1'b0;
        bus_if.bus_rdata = 32'h77777777;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        check("pre_rst_req", 32'(bus_if.bus_req), 32'd1);
        reset_n = 1'b0;
        #1;
        check("async_rst_req", 32'(bus_if.bus_req), 32'd0);
        check("async_rst_addr", bus_if.bus_addr, 32'd0);
        set_nop();
        @(posedge clk); @(negedge clk);
        reset_n = 1'b1;
        bus_if.bus_ack = 1'b1;
        @(posedge clk); @(negedge clk);
        bus_if.bus_ack = 1'b0;
        model_rdata = '0;
        check("late_ack_req", 32'(bus_if.bus_req), 32'd0);
        check("late_ack_data", mem_read_data_out, 32'd0);
        check("late_ack_stall", 32'(stall_out), 32'd0);
        run_op(1, 0, 32'h500, 32'h0, 2'd1, 0, 1, 32'h0000FFFE);
        check("post_rst_lh", mem_read_data_out, 32'hFFFFFFFE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM-stage access unit between the EX/MEM register and the MEM_WB register of the 5-stage MIPS pipeline.
- Turns load/store control from EX/MEM into a req/ack transaction on the data-memory bus.
- Formats load data for byte, halfword or word width with sign or zero extension.
- Stalls the upstream pipeline while an access is outstanding and presents WB-bound fields for MEM_WB to capture.

Parameters:
- TIMEOUT_CYCLES, 16: maximum REQ-state cycles before abort; used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- alu_result_in  in  32  effective address / ALU result from EX/MEM
- write_data_in  in  32  store data (rt)
- rd_in  in  5  destination register
- reg_write_in, mem_to_reg_in  in  1 each  WB control
- mem_read_in, mem_write_in  in  1 each  load / store request
- size_in  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- unsigned_in  in  1  1 = zero-extend loads (lbu/lhu)
- bus_req  out  1  registered request
- bus_we  out  1  registered write enable
- bus_addr  out  32  registered word address, [1:0] = 0
- bus_wdata  out  32  registered lane-replicated store data
- bus_be  out  4  registered byte enables
- bus_ack  in  1  one-cycle completion strobe
- bus_rdata  in  32  read data, valid with bus_ack
- mem_read_data_out  out  32  registered formatted load data to MEM_WB
- alu_result_out, rd_out, mem_to_reg_out  out  32/5/1  combinational pass-through
- reg_write_out  out  1  reg_write_in & ~misalign_out
- stall_out  out  1  hold PC, IF/ID, ID/EX and EX/MEM
- misalign_out  out  1  combinational alignment fault
- bus_err_out  out  1  registered timeout flag (MEM_TIMEOUT_EN only, else 0)

Behaviour:
- Reset (reset_n low, asynchronous): state IDLE; bus_req, bus_we, bus_addr, bus_wdata, bus_be, mem_read_data_out, bus_err_out all 0.
- Reset mid-transaction drops bus_req immediately; a late bus_ack afterwards is ignored.
- access = (mem_read_in | mem_write_in) & ~misalign_out.
- misalign_out = access request with (half & addr[0]) or (word & addr[1:0] != 0). A misaligned access issues no bus request, does not stall, and forces reg_write_out to 0.
- If mem_read_in and mem_write_in are both 1, the access is a store.
- stall_out = access & (state != DONE).
- FSM:
  - IDLE: on access, latch bus_addr = {addr[31:2],2'b00}, bus_we, bus_be and bus_wdata; set bus_req = 1; go to REQ.
  - REQ: hold bus_req and all bus outputs stable until bus_ack. On the bus_ack edge: bus_req = 0; if load, latch formatted data into mem_read_data_out; go to DONE.
  - DONE: stall_out = 0, so MEM_WB samples and EX/MEM advances; go to IDLE on the next edge.
- Minimum load/store cost is 2 stall cycles (IDLE + REQ with immediate ack). Back-to-back accesses always pass through IDLE.
- Non-memory instructions: no stall; mem_read_data_out holds its previous value.
- Byte enables, little-endian, from addr[1:0]:
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << addr[1:0]
  - word: 4'b1111
- Store data: byte replicated ×4, half replicated ×2, word unchanged.
- Load: select lane by addr[1:0], then sign-extend from bit 7/15 unless unsigned_in. Word loads pass bus_rdata unchanged.
- bus_ack outside REQ is ignored.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - REQ keeps a cycle counter, cleared on entry to REQ.
  - If the counter reaches TIMEOUT_CYCLES with no ack: bus_req = 0, mem_read_data_out = 0, bus_err_out = 1, go to DONE.
  - bus_err_out clears on the next access leaving IDLE.
- Undefined: no counter; REQ waits indefinitely; bus_err_out tied to 0.

Test Plan:
- lw addr 0x100, ack in the 1st REQ cycle, rdata 0xDEADBEEF -> bus_be 1111, stall high 2 cycles, mem_read_data_out 0xDEADBEEF in DONE, reg_write_out 1.
- lb addr 0x103, rdata 0x80112233 -> bus_be 1000, out 0xFFFFFF80; same with lbu -> 0x00000080.
- sh addr 0x102, write_data 0x0000ABCD -> bus_we 1, bus_be 1100, bus_wdata 0xABCDABCD, bus_addr 0x100.
- lw addr 0x101 -> misalign_out 1, no bus_req, stall 0, reg_write_out 0.
- ack delayed 5 cycles -> stall 6 cycles, bus outputs stable throughout; reset_n low during REQ -> bus_req 0 immediately, state IDLE.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES 16, no ack -> abort after 16 REQ cycles, bus_err_out 1, mem_read_data_out 0.
